// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared defaults, channel map and counter sizing for the switch debouncer
package sw_debounce_pkg;
  localparam int unsigned DefTickCycles = 30_000;
  localparam int unsigned DefStableTicks = 5;
  localparam int unsigned NavSwLsb = 0;
  localparam int unsigned UsrSwLsb = 5;
  function automatic int unsigned cnt_width(input int unsigned stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one switch channel - two-flop synchroniser, tick-based stability counter, edge pulses
module debounce_chan import sw_debounce_pkg::*; #(
  parameter int unsigned StableTicks = DefStableTicks,
  parameter bit InvertIn = 1'b1,
  parameter bit ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic sw,
  output logic rise,
  output logic fall
);
  localparam int unsigned CW = cnt_width(StableTicks);
  logic [1:0] sync;
  logic [CW-1:0] c, c_nxt;
  logic s, match, done;
  // any return to the stable level restarts qualification from zero
  always_comb begin
    s = sync[1] ^ InvertIn;
    match = s == sw;
    done = !match && tick && c == CW'(StableTicks - 1);
    c_nxt = (match || done) ? '0 : tick ? c + CW'(1) : c;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= {2{ResetVal ^ InvertIn}};
      c <= '0;
      sw <= ResetVal;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      c <= c_nxt;
      sw <= done ? s : sw;
      rise <= done && s;
      fall <= done && !s;
    end
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: synchronised, debounced switch levels with rise/fall pulses and a shared tick prescaler
module sw_debounce import sw_debounce_pkg::*; #(
  parameter int unsigned Width = 13,
  parameter int unsigned TickCycles = DefTickCycles,
  parameter int unsigned StableTicks = DefStableTicks,
  parameter bit InvertIn = 1'b1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] sw_raw_i,
  output logic [Width-1:0] sw_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             tick_o
);
  localparam int unsigned PW = TickCycles > 1 ? $clog2(TickCycles) : 1;
  if (TickCycles < 1) begin : g_bad_tick
    $error("sw_debounce: TickCycles must be >= 1");
  end
  if (StableTicks < 1) begin : g_bad_stable
    $error("sw_debounce: StableTicks must be >= 1");
  end
  logic [PW-1:0] cnt;
  // with TickCycles == 1 the counter sits at 0 and tick stays high
  assign tick_o = cnt == PW'(TickCycles - 1);
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni)
    if (!rst_sys_ni) cnt <= '0;
    else cnt <= tick_o ? '0 : cnt + PW'(1);
  for (genvar i = 0; i < Width; i++) begin : g_chan
    debounce_chan #(
      .StableTicks(StableTicks),
      .InvertIn   (InvertIn),
      .ResetVal   (ResetVal[i])
    ) u_chan (
      .clk  (clk_sys_i),
      .rst_n(rst_sys_ni),
      .tick (tick_o),
      .raw  (sw_raw_i[i]),
      .sw   (sw_o[i]),
      .rise (rise_o[i]),
      .fall (fall_o[i])
    );
  end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: randomized + directed scoreboard bench; model predicts each level change from tick arithmetic
module tb_sw_debounce;
  localparam int W = 13;
  localparam int TC = 4;
  localparam int ST = 3;
  typedef struct {int t; int b; logic dir;} ev_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [W-1:0] raw, sw, rise, fall;
  logic tick;
  int checks = 0;
  int errors = 0;
  ev_t q[$];
  logic [W-1:0] lvl, d1, d2, s_m;
  int dl[W];
  bit armed[W];
  int cyc = 0;
  int rise_cnt[W];
  sw_debounce #(.Width(W), .TickCycles(TC), .StableTicks(ST), .InvertIn(1'b1), .ResetVal('0)) dut (
    .clk_sys_i(clk), .rst_sys_ni(rst_n), .sw_raw_i(raw),
    .sw_o(sw), .rise_o(rise), .fall_o(fall), .tick_o(tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask
  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d..%0d", nm, act, lo, hi);
    end
  endtask
  // reference: once s differs from the level at cycle t, the change lands on the ST-th tick at or after t
  always @(posedge clk) begin
    if (!rst_n) begin
      lvl = '0; d1 = '1; d2 = '1; cyc = 0;
      for (int i = 0; i < W; i++) armed[i] = 0;
      q.delete();
    end else begin
      s_m = ~d2;
      d2 = d1;
      d1 = raw;
      for (int i = 0; i < W; i++) begin
        if (s_m[i] == lvl[i]) armed[i] = 0;
        else begin
          if (!armed[i]) begin
            armed[i] = 1;
            dl[i] = cyc + (TC - 1 - cyc % TC) + TC * (ST - 1);
          end
          if (cyc == dl[i]) begin
            lvl[i] = s_m[i];
            armed[i] = 0;
            q.push_back('{cyc, i, s_m[i]});
          end
        end
      end
      cyc++;
    end
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_sw", int'(sw), 0);
      chk("rst_pulse", int'(rise | fall), 0);
      chk("rst_tick", int'(tick), 0);
    end else begin
      chk("sw_level", int'(sw), int'(lvl));
      chk("tick", int'(tick), int'(cyc % TC == TC - 1));
      for (int i = 0; i < W; i++) begin
        if (rise[i] || fall[i]) begin
          if (rise[i]) rise_cnt[i]++;
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse bit=%0d rise=%0d fall=%0d expected none", i, rise[i], fall[i]);
          end else begin
            ev_t e;
            e = q.pop_front();
            if (e.t != cyc - 1 || e.b != i || e.dir != rise[i] || (rise[i] && fall[i])) begin
              errors++;
              $display("FAIL pulse bit=%0d cyc=%0d rise=%0d fall=%0d expected bit=%0d cyc=%0d rise=%0d",
                       i, cyc - 1, rise[i], fall[i], e.b, e.t, e.dir);
            end
          end
        end
      end
      while (q.size() > 0 && q[0].t <= cyc - 1) begin
        checks++;
        errors++;
        $display("FAIL missing_pulse bit=%0d cyc=%0d rise=%0d got none", q[0].b, q[0].t, q[0].dir);
        void'(q.pop_front());
      end
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic wait_bit(input int b, input logic v, output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #2;
      n++;
      if (sw[b] === v) break;
    end
  endtask
  initial begin
    int n, r0;
    rst_n = 1'b0;
    raw = '1;
    for (int i = 0; i < W; i++) rise_cnt[i] = 0;
    step(3);
    rst_n = 1'b1;
    step(12);
    raw[0] = 1'b0;
    wait_bit(0, 1'b1, n);
    chk_rng("press_latency", n, 11, 14);
    chk("press_rise", int'(rise[0]), 1);
    chk("press_fall", int'(fall[0]), 0);
    step(7);
    raw[0] = 1'b1;
    wait_bit(0, 1'b0, n);
    chk_rng("release_latency", n, 11, 14);
    chk("release_fall", int'(fall[0]), 1);
    step(5);
    r0 = rise_cnt[3];
    for (int k = 0; k < 14; k++) begin
      raw[3] = ~raw[3];
      step(3);
    end
    chk("bounce_no_rise", rise_cnt[3], r0);
    chk("bounce_sw", int'(sw[3]), 0);
    raw[3] = 1'b0;
    wait_bit(3, 1'b1, n);
    chk_rng("bounce_latency", n, 11, 14);
    step(10);
    chk("bounce_one_rise", rise_cnt[3], r0 + 1);
    raw[3] = 1'b1;
    step(20);
    raw = '0;
    n = 0;
    while (sw == '0 && n < 40) begin
      step(1);
      n++;
    end
    chk("multi_sw", int'(sw), 13'h1fff);
    chk("multi_rise", int'(rise), 13'h1fff);
    step(5);
    raw = '1;
    step(20);
    raw[5] = 1'b0;
    step(8);
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_sw", int'(sw[5]), 0);
    chk("post_rst_rise", int'(rise[5]), 0);
    wait_bit(5, 1'b1, n);
    chk_rng("requal_latency", n, 10, 13);
    step(5);
    raw = '1;
    step(20);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = $urandom_range(0, W - 1);
        raw[b] = ~raw[b];
      end
      step(1);
    end
    raw = '1;
    step(25);
    chk("sb_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
